// File: rtl/control_sequencer.sv
// control_sequencer: registered control strobes, multi-cycle memory sequencing, halt, retire count.
// Define MEM_ACK_EN to end memory accesses on MemAck rather than after MEM_LAT cycles.
module control_sequencer #(
  parameter int OP_W       = 4,
  parameter int MEM_LAT    = 2,
  parameter int INST_CNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  InstValid,
  input  logic                  TypeBit,
  input  logic [OP_W-1:0]       OP,
  input  logic                  Resume,
`ifdef MEM_ACK_EN
  input  logic                  MemAck,
`endif
  output logic                  InstReady,
  output logic                  Stall,
  output logic                  RWrite,
  output logic                  AWrite,
  output logic                  ReadMem,
  output logic                  WriteMem,
  output logic                  LookUp,
  output logic                  isMem,
  output logic                  Halt,
  output logic [INST_CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM,
    S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic                  lw_q, lw_d;
  logic                  rw_q, rw_d;
  logic                  aw_q, aw_d;
  logic                  rm_q, rm_d;
  logic                  wm_q, wm_d;
  logic                  lu_q, lu_d;
  logic                  im_q, im_d;
  logic                  halt_q, halt_d;
  logic [INST_CNT_W-1:0] cnt_q, cnt_d;
  logic                  retire;

`ifndef MEM_ACK_EN
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  logic [3:0] lat_q, lat_d;
`endif

  // Zero-extend so opcodes >= 16 are visible for any OP_W
  logic [31:0] op_x;
  logic c_acc, c_reg, c_lut, c_lw, c_sw, c_hlt, c_nop;

  assign op_x = 32'(OP);

  always_comb begin
    c_acc = !TypeBit ||
            (op_x inside {32'd0, 32'd4, 32'd5, 32'd6, [32'd9:32'd14]});
    c_reg = TypeBit && (op_x == 32'd1);
    c_lw  = TypeBit && (op_x == 32'd2);
    c_sw  = TypeBit && (op_x == 32'd3);
    c_lut = TypeBit && (op_x inside {32'd7, 32'd8});
    c_hlt = TypeBit && (op_x == 32'd15);
    c_nop = TypeBit && (op_x >= 32'd16);
  end

  always_comb begin
    state_d = state_q;
    lw_d    = lw_q;
    halt_d  = halt_q;
    rw_d    = 1'b0;
    aw_d    = 1'b0;
    rm_d    = 1'b0;
    wm_d    = 1'b0;
    lu_d    = 1'b0;
    im_d    = 1'b0;
    retire  = 1'b0;
`ifndef MEM_ACK_EN
    lat_d   = lat_q;
`endif
    unique case (state_q)
      S_RUN: begin
        if (InstValid) begin
          unique case (1'b1)
            c_acc: begin
              aw_d   = 1'b1;
              retire = 1'b1;
            end
            c_reg: begin
              rw_d   = 1'b1;
              retire = 1'b1;
            end
            c_lut: begin
              lu_d   = 1'b1;
              retire = 1'b1;
            end
            c_nop: retire = 1'b1;
            c_hlt: begin
              state_d = S_HALT;
              halt_d  = 1'b1;
              retire  = 1'b1;
            end
            c_lw, c_sw: begin
              state_d = S_MEM;
              lw_d    = c_lw;
              rm_d    = c_lw;
              im_d    = c_lw;
              wm_d    = c_sw;
`ifndef MEM_ACK_EN
              lat_d   = LAT_M1;
              if (MEM_LAT == 1) begin
                aw_d   = c_lw;
                retire = 1'b1;
              end
`endif
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
`ifdef MEM_ACK_EN
        if (MemAck) begin
          state_d = S_RUN;
          aw_d    = lw_q;
          retire  = 1'b1;
        end else begin
          rm_d = lw_q;
          im_d = lw_q;
          wm_d = !lw_q;
        end
`else
        if (lat_q == 4'd0) begin
          state_d = S_RUN;
        end else begin
          lat_d = lat_q - 4'd1;
          rm_d  = lw_q;
          im_d  = lw_q;
          wm_d  = !lw_q;
          // Entering the final access cycle
          if (lat_q == 4'd1) begin
            aw_d   = lw_q;
            retire = 1'b1;
          end
        end
`endif
      end
      S_HALT: begin
        if (Resume) begin
          state_d = S_RUN;
          halt_d  = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase
    cnt_d = cnt_q + INST_CNT_W'(retire);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_RUN;
      lw_q    <= 1'b0;
      rw_q    <= 1'b0;
      aw_q    <= 1'b0;
      rm_q    <= 1'b0;
      wm_q    <= 1'b0;
      lu_q    <= 1'b0;
      im_q    <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
`ifndef MEM_ACK_EN
      lat_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      lw_q    <= lw_d;
      rw_q    <= rw_d;
      aw_q    <= aw_d;
      rm_q    <= rm_d;
      wm_q    <= wm_d;
      lu_q    <= lu_d;
      im_q    <= im_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
`ifndef MEM_ACK_EN
      lat_q   <= lat_d;
`endif
    end
  end

  assign InstReady = (state_q == S_RUN);
  assign Stall     = ~InstReady;
  assign RWrite    = rw_q;
  assign AWrite    = aw_q;
  assign ReadMem   = rm_q;
  assign WriteMem  = wm_q;
  assign LookUp    = lu_q;
  assign isMem     = im_q;
  assign Halt      = halt_q;
  assign InstCount = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of control_sequencer
// against a transaction-level schedule model.
module tb_control_sequencer;

  localparam int OW  = 5;
  localparam int LAT = 3;
  localparam int CW  = 4;

  localparam bit [5:0] B_RW = 6'b100000;
  localparam bit [5:0] B_AW = 6'b010000;
  localparam bit [5:0] B_RM = 6'b001000;
  localparam bit [5:0] B_WM = 6'b000100;
  localparam bit [5:0] B_LU = 6'b000010;
  localparam bit [5:0] B_IM = 6'b000001;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          InstValid = 1'b0;
  logic          TypeBit = 1'b0;
  logic [OW-1:0] OP = '0;
  logic          Resume = 1'b0;
`ifdef MEM_ACK_EN
  logic          MemAck = 1'b0;
`endif
  logic          InstReady, Stall, RWrite, AWrite;
  logic          ReadMem, WriteMem, LookUp, isMem, Halt;
  logic [CW-1:0] InstCount;
  logic [8:0]    act_st;

  int errors = 0;
  int checks = 0;

  // Model: strobe schedule per future cycle, retire marks, halt/mem state
  bit [5:0]      sched [64];
  bit            ret [64];
  int            cyc;
  int            free_at;
  bit            m_halt, m_mem, m_lw;
  logic [CW-1:0] m_cnt;
  logic [8:0]    exp_st;

  control_sequencer #(
    .OP_W(OW),
    .MEM_LAT(LAT),
    .INST_CNT_W(CW)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .InstValid(InstValid),
    .TypeBit(TypeBit),
    .OP(OP),
    .Resume(Resume),
`ifdef MEM_ACK_EN
    .MemAck(MemAck),
`endif
    .InstReady(InstReady),
    .Stall(Stall),
    .RWrite(RWrite),
    .AWrite(AWrite),
    .ReadMem(ReadMem),
    .WriteMem(WriteMem),
    .LookUp(LookUp),
    .isMem(isMem),
    .Halt(Halt),
    .InstCount(InstCount)
  );

  always #5 Clk = ~Clk;

  assign act_st = {InstReady, Stall, RWrite, AWrite,
                   ReadMem, WriteMem, LookUp, isMem, Halt};

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      sched[i] = '0;
      ret[i] = 1'b0;
    end
    cyc = 0;
    free_at = 0;
    m_halt = 1'b0;
    m_mem = 1'b0;
    m_lw = 1'b0;
    m_cnt = '0;
    exp_st = 9'h100;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    InstValid = 1'b0;
    Resume = 1'b0;
`ifdef MEM_ACK_EN
    MemAck = 1'b0;
`endif
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
  endtask

  // Drive one cycle of inputs and advance the model to the next cycle
  task automatic step(input bit v, input bit t, input logic [OW-1:0] op,
                      input bit res, input bit ack);
    bit rdy, nh, nm, nl, rdy_n;
    int e, s;
    @(negedge Clk);
    InstValid = v;
    TypeBit = t;
    OP = op;
    Resume = res;
`ifdef MEM_ACK_EN
    MemAck = ack;
`endif
    e = cyc + 1;
    s = e % 64;
    rdy = !m_halt && !m_mem && (cyc >= free_at);
    nh = m_halt;
    nm = m_mem;
    nl = m_lw;
    if (m_halt && res) nh = 1'b0;
`ifdef MEM_ACK_EN
    if (m_mem) begin
      if (ack) begin
        nm = 1'b0;
        if (m_lw) sched[s] |= B_AW;
        ret[s] = 1'b1;
      end else begin
        sched[s] |= m_lw ? (B_RM | B_IM) : B_WM;
      end
    end
`endif
    if (rdy && v) begin
      if (!t || (op inside {0, 4, 5, 6, [9:14]})) begin
        sched[s] |= B_AW;
        ret[s] = 1'b1;
      end else if (op == 1) begin
        sched[s] |= B_RW;
        ret[s] = 1'b1;
      end else if (op == 7 || op == 8) begin
        sched[s] |= B_LU;
        ret[s] = 1'b1;
      end else if (op == 15) begin
        nh = 1'b1;
        ret[s] = 1'b1;
      end else if (op == 2 || op == 3) begin
`ifdef MEM_ACK_EN
        nm = 1'b1;
        nl = (op == 2);
        sched[s] |= (op == 2) ? (B_RM | B_IM) : B_WM;
`else
        for (int k = 0; k < LAT; k++)
          sched[(e + k) % 64] |= (op == 2) ? (B_RM | B_IM) : B_WM;
        if (op == 2) sched[(e + LAT - 1) % 64] |= B_AW;
        ret[(e + LAT - 1) % 64] = 1'b1;
        free_at = e + LAT;
`endif
      end else begin
        ret[s] = 1'b1;
      end
    end
    @(posedge Clk);
    #1;
    cyc = e;
    m_halt = nh;
    m_mem = nm;
    m_lw = nl;
    if (ret[s]) m_cnt = m_cnt + 1'b1;
    rdy_n = !m_halt && !m_mem && (cyc >= free_at);
    exp_st = {rdy_n, !rdy_n, sched[s], m_halt};
    sched[s] = '0;
    ret[s] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    checks++;
    if (act_st !== 9'h100 || InstCount !== '0) begin
      errors++;
      $display("FAIL reset: st=%h cnt=%0d want st=100 cnt=0",
               act_st, InstCount);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
  endtask

  task automatic test_geti_override();
    do_reset();
    step(1, 0, 5'd3, 0, 0);
    checks++;
    if (AWrite !== 1'b1 || WriteMem !== 1'b0 || InstCount !== 4'd1 ||
        act_st !== exp_st) begin
      errors++;
      $display("FAIL geti: st=%h cnt=%0d want st=%h cnt=1",
               act_st, InstCount, exp_st);
    end
    step(0, 1, 5'd1, 0, 0);
    checks++;
    if (act_st !== 9'h100) begin
      errors++;
      $display("FAIL idle: st=%h want 100", act_st);
    end
  endtask

`ifndef MEM_ACK_EN
  task automatic test_lw_back_to_back();
    do_reset();
    for (int k = 0; k < LAT; k++) begin
      if (k == 0) step(1, 1, 5'd2, 0, 0);
      else step(1, 1, 5'd1, 0, 0);
      checks++;
      if (ReadMem !== 1'b1 || isMem !== 1'b1 || InstReady !== 1'b0 ||
          AWrite !== (k == LAT - 1) || act_st !== exp_st) begin
        errors++;
        $display("FAIL lw_cycle%0d: st=%h want %h", k, act_st, exp_st);
      end
    end
    step(0, 1, 5'd1, 0, 0);
    checks++;
    if (ReadMem !== 1'b0 || InstReady !== 1'b1 || InstCount !== 4'd1) begin
      errors++;
      $display("FAIL lw_exit: st=%h cnt=%0d want rdy=1 cnt=1",
               act_st, InstCount);
    end
    step(1, 1, 5'd1, 0, 0);
    checks++;
    if (RWrite !== 1'b1 || InstCount !== 4'd2) begin
      errors++;
      $display("FAIL back_to_back: rw=%b cnt=%0d want rw=1 cnt=2",
               RWrite, InstCount);
    end
  endtask
`endif

  task automatic test_halt();
    do_reset();
    step(1, 1, 5'd15, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(1, 1, 5'd1, 0, 0);
      checks++;
      if (Halt !== 1'b1 || InstReady !== 1'b0 || act_st !== exp_st) begin
        errors++;
        $display("FAIL halt_cycle%0d: st=%h want %h", k, act_st, exp_st);
      end
    end
    step(1, 1, 5'd1, 1, 0);
    checks++;
    if (Halt !== 1'b0 || InstReady !== 1'b1 || RWrite !== 1'b0 ||
        InstCount !== 4'd1) begin
      errors++;
      $display("FAIL resume: st=%h cnt=%0d want st=100 cnt=1",
               act_st, InstCount);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    bit wrapped;
    logic [CW-1:0] prev;
    do_reset();
    pulses = 0;
    wrapped = 1'b0;
    prev = '0;
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 5'd0, 0, 0);
      if (AWrite === 1'b1) pulses++;
      if (prev == 4'd15 && InstCount === 4'd0) wrapped = 1'b1;
      prev = InstCount;
    end
    checks++;
    if (pulses != 17 || !wrapped || InstCount !== 4'd1) begin
      errors++;
      $display("FAIL wrap: pulses=%0d wrapped=%b cnt=%0d want 17 1 1",
               pulses, wrapped, InstCount);
    end
  endtask

  task automatic test_reset_mid_lw();
    do_reset();
    step(1, 0, 5'd0, 0, 0);
    step(1, 1, 5'd2, 0, 0);
    step(0, 1, 5'd0, 0, 0);
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (act_st !== 9'h100 || InstCount !== '0) begin
      errors++;
      $display("FAIL reset_mid_lw: st=%h cnt=%0d want st=100 cnt=0",
               act_st, InstCount);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    model_clear();
  endtask

`ifdef MEM_ACK_EN
  task automatic test_mem_ack();
    int wm_cycles;
    do_reset();
    wm_cycles = 0;
    step(1, 1, 5'd3, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      if (WriteMem === 1'b1) wm_cycles++;
      step(0, 1, 5'd0, 0, (k == 4));
    end
    checks++;
    if (wm_cycles != 4 || WriteMem !== 1'b0 || InstReady !== 1'b1) begin
      errors++;
      $display("FAIL mem_ack: wm_cycles=%0d st=%h want 4 rdy=1",
               wm_cycles, act_st);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 5) != 0,
           OW'($urandom % 32), ($urandom % 3) == 0, ($urandom % 3) == 0);
      checks++;
      if (act_st !== exp_st || InstCount !== m_cnt) begin
        errors++;
        $display("FAIL random%0d: st=%h cnt=%0d want st=%h cnt=%0d",
                 i, act_st, InstCount, exp_st, m_cnt);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_geti_override();
`ifndef MEM_ACK_EN
    test_lw_back_to_back();
`else
    test_mem_ack();
`endif
    test_halt();
    test_wrap();
    test_reset_mid_lw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
